// File: rtl/axi_protocol_monitor.sv
// Passive AXI4 checker: payload stability, VALID retraction, LAST position, orphan and
// overflow detection with sticky flags, first-error code and saturating error counter.
module axi_protocol_monitor #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned ERR_CNT_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ID_WIDTH-1:0]                  awid,
    input  logic [ADDR_WIDTH-1:0]                awaddr,
    input  logic [LEN_WIDTH-1:0]                 awlen,
    input  logic [2:0]                           awsize,
    input  logic [1:0]                           awburst,
    input  logic                                 awvalid,
    input  logic                                 awready,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic [DATA_WIDTH/8-1:0]              wstrb,
    input  logic                                 wlast,
    input  logic                                 wvalid,
    input  logic                                 wready,
    input  logic [ID_WIDTH-1:0]                  bid,
    input  logic [1:0]                           bresp,
    input  logic                                 bvalid,
    input  logic                                 bready,
    input  logic [ID_WIDTH-1:0]                  arid,
    input  logic [ADDR_WIDTH-1:0]                araddr,
    input  logic [LEN_WIDTH-1:0]                 arlen,
    input  logic [2:0]                           arsize,
    input  logic [1:0]                           arburst,
    input  logic                                 arvalid,
    input  logic                                 arready,
    input  logic [ID_WIDTH-1:0]                  rid,
    input  logic [DATA_WIDTH-1:0]                rdata,
    input  logic [1:0]                           rresp,
    input  logic                                 rlast,
    input  logic                                 rvalid,
    input  logic                                 rready,
    input  logic                                 clr,
    output logic [7:0]                           err_vec,
    output logic                                 err_first_valid,
    output logic [2:0]                           err_first_code,
    output logic [ERR_CNT_WIDTH-1:0]             err_cnt,
    output logic [$clog2(MAX_OUTSTANDING)+1:0]   wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING):0]     rd_outstanding
);

    localparam int unsigned PW  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned AXW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5;
    localparam int unsigned WXW = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [AXW-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
    logic [WXW-1:0] w_pl, w_pl_q;
    logic aw_stall_q, w_stall_q, b_stall_q, ar_stall_q, r_stall_q;

    logic [LEN_WIDTH-1:0] aw_mem [MAX_OUTSTANDING];
    logic [LEN_WIDTH-1:0] ar_mem [MAX_OUTSTANDING];
    logic [PW-1:0]        aw_wptr_q, aw_rptr_q, ar_wptr_q, ar_rptr_q;
    logic [CW-1:0]        aw_cnt_q, aw_cnt_d, ar_cnt_q, ar_cnt_d, b_pend_q, b_pend_d;
    logic [LEN_WIDTH-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, w_head, r_head;

    logic aw_empty, aw_full, w_tracked, w_pop, aw_push, aw_ovf, b_dec;
    logic ar_empty, ar_full, r_tracked, r_pop, ar_push, ar_ovf;

    logic [7:0]               new_err, vec_base, err_vec_d;
    logic [2:0]               new_code, code_base, code_d;
    logic                     fv_base, fv_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_base, cnt_d;

    logic unused_sig;
    assign unused_sig = ^{bid, bresp, rid, rdata, rresp};

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    assign aw_pl = {awid, awaddr, awlen, awsize, awburst};
    assign ar_pl = {arid, araddr, arlen, arsize, arburst};
    assign w_pl  = {wdata, wstrb, wlast};

    // Write side: a first W beat may pair with an AW accepted in the same cycle.
    assign aw_empty  = (aw_cnt_q == '0);
    assign aw_full   = (aw_cnt_q == FULL);
    assign w_head    = aw_empty ? awlen : aw_mem[aw_rptr_q];
    assign w_tracked = w_hs & (~aw_empty | aw_hs);
    assign w_pop     = w_tracked & wlast;
    assign b_dec     = b_hs & (b_pend_q != '0);
    assign aw_push   = aw_hs & (~aw_full | w_pop);
    assign aw_ovf    = aw_hs & aw_full & (~w_pop | ((b_pend_q == FULL) & ~b_dec));

    assign ar_empty  = (ar_cnt_q == '0);
    assign ar_full   = (ar_cnt_q == FULL);
    assign r_head    = ar_mem[ar_rptr_q];
    assign r_tracked = r_hs & ~ar_empty;
    assign r_pop     = r_tracked & rlast;
    assign ar_push   = ar_hs & (~ar_full | r_pop);
    assign ar_ovf    = ar_hs & ar_full & ~r_pop;

    always_comb begin
        new_err    = '0;
        new_err[0] = aw_stall_q & (aw_pl != aw_pl_q);
        new_err[1] = w_stall_q & (w_pl != w_pl_q);
        new_err[2] = ar_stall_q & (ar_pl != ar_pl_q);
        new_err[3] = (aw_stall_q & ~awvalid) | (w_stall_q & ~wvalid) | (b_stall_q & ~bvalid) |
                     (ar_stall_q & ~arvalid) | (r_stall_q & ~rvalid);
        new_err[4] = w_tracked & (wlast != (wcnt_q == w_head));
        new_err[5] = r_tracked & (rlast != (rcnt_q == r_head));
        new_err[6] = (w_hs & aw_empty & ~aw_hs) | (b_hs & (b_pend_q == '0)) | (r_hs & ar_empty);
        new_err[7] = aw_ovf | ar_ovf;
    end

    always_comb begin
        new_code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (new_err[i]) new_code = 3'(i);
        end
    end

    always_comb begin
        aw_cnt_d = aw_cnt_q;
        if (aw_push && !w_pop)      aw_cnt_d = aw_cnt_q + CW'(1);
        else if (!aw_push && w_pop) aw_cnt_d = aw_cnt_q - CW'(1);

        ar_cnt_d = ar_cnt_q;
        if (ar_push && !r_pop)      ar_cnt_d = ar_cnt_q + CW'(1);
        else if (!ar_push && r_pop) ar_cnt_d = ar_cnt_q - CW'(1);

        b_pend_d = b_pend_q;
        if (w_pop && !b_dec) begin
            if (b_pend_q != FULL) b_pend_d = b_pend_q + CW'(1);
        end else if (!w_pop && b_dec) begin
            b_pend_d = b_pend_q - CW'(1);
        end

        wcnt_d = wcnt_q;
        if (w_pop)                           wcnt_d = '0;
        else if (w_tracked && wcnt_q != '1)  wcnt_d = wcnt_q + LEN_WIDTH'(1);

        rcnt_d = rcnt_q;
        if (r_pop)                           rcnt_d = '0;
        else if (r_tracked && rcnt_q != '1)  rcnt_d = rcnt_q + LEN_WIDTH'(1);
    end

    // Clear first, then this cycle's violations land on top.
    always_comb begin
        vec_base  = clr ? '0 : err_vec;
        fv_base   = clr ? 1'b0 : err_first_valid;
        code_base = clr ? 3'd0 : err_first_code;
        cnt_base  = clr ? '0 : err_cnt;
        err_vec_d = vec_base | new_err;
        fv_d      = fv_base;
        code_d    = code_base;
        cnt_d     = cnt_base;
        if (|new_err) begin
            if (!fv_base) begin
                fv_d   = 1'b1;
                code_d = new_code;
            end
            if (cnt_base != '1) cnt_d = cnt_base + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (aw_push) aw_mem[aw_wptr_q] <= awlen;
        if (ar_push) ar_mem[ar_wptr_q] <= arlen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_stall_q      <= 1'b0;
            w_stall_q       <= 1'b0;
            b_stall_q       <= 1'b0;
            ar_stall_q      <= 1'b0;
            r_stall_q       <= 1'b0;
            aw_pl_q         <= '0;
            w_pl_q          <= '0;
            ar_pl_q         <= '0;
            aw_wptr_q       <= '0;
            aw_rptr_q       <= '0;
            ar_wptr_q       <= '0;
            ar_rptr_q       <= '0;
            aw_cnt_q        <= '0;
            ar_cnt_q        <= '0;
            b_pend_q        <= '0;
            wcnt_q          <= '0;
            rcnt_q          <= '0;
            err_vec         <= '0;
            err_first_valid <= 1'b0;
            err_first_code  <= '0;
            err_cnt         <= '0;
        end else begin
            aw_stall_q      <= awvalid & ~awready;
            w_stall_q       <= wvalid & ~wready;
            b_stall_q       <= bvalid & ~bready;
            ar_stall_q      <= arvalid & ~arready;
            r_stall_q       <= rvalid & ~rready;
            aw_pl_q         <= aw_pl;
            w_pl_q          <= w_pl;
            ar_pl_q         <= ar_pl;
            if (aw_push) aw_wptr_q <= aw_wptr_q + PW'(1);
            if (w_pop)   aw_rptr_q <= aw_rptr_q + PW'(1);
            if (ar_push) ar_wptr_q <= ar_wptr_q + PW'(1);
            if (r_pop)   ar_rptr_q <= ar_rptr_q + PW'(1);
            aw_cnt_q        <= aw_cnt_d;
            ar_cnt_q        <= ar_cnt_d;
            b_pend_q        <= b_pend_d;
            wcnt_q          <= wcnt_d;
            rcnt_q          <= rcnt_d;
            err_vec         <= err_vec_d;
            err_first_valid <= fv_d;
            err_first_code  <= code_d;
            err_cnt         <= cnt_d;
        end
    end

    assign wr_outstanding = {1'b0, aw_cnt_q} + {1'b0, b_pend_q};
    assign rd_outstanding = ar_cnt_q;

`ifndef SYNTHESIS
    x_on_handshake: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({awvalid, awready, wvalid, wready, bvalid, bready,
                     arvalid, arready, rvalid, rready}));
`endif

endmodule

// File: tb/tb_axi_protocol_monitor.sv
// Bench for axi_protocol_monitor: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model.
module tb_axi_protocol_monitor;

    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 8, MAXO = 8, CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic [ID_W-1:0] awid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [LEN_W-1:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic [DATA_W-1:0] wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready, clr;
    logic [7:0] err_vec;
    logic err_first_valid;
    logic [2:0] err_first_code;
    logic [CNT_W-1:0] err_cnt;
    logic [$clog2(MAXO)+1:0] wr_outstanding;
    logic [$clog2(MAXO):0] rd_outstanding;

    axi_protocol_monitor #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .LEN_WIDTH(LEN_W),
        .MAX_OUTSTANDING(MAXO), .ERR_CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .clr(clr),
        .err_vec(err_vec), .err_first_valid(err_first_valid), .err_first_code(err_first_code),
        .err_cnt(err_cnt), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_aw_q[$];
    int m_ar_q[$];
    int m_wcnt, m_rcnt, m_bpend;
    bit p_aw_stall, p_w_stall, p_b_stall, p_ar_stall, p_r_stall;
    logic [ID_W+ADDR_W+LEN_W+4:0] p_aw, p_ar;
    logic [DATA_W+DATA_W/8:0] p_w;
    logic [7:0] m_vec;
    bit m_fv;
    int m_code, m_cnt;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_aw_q.delete();
        m_ar_q.delete();
        m_wcnt = 0; m_rcnt = 0; m_bpend = 0;
        p_aw_stall = 0; p_w_stall = 0; p_b_stall = 0; p_ar_stall = 0; p_r_stall = 0;
        p_aw = '0; p_ar = '0; p_w = '0;
        m_vec = '0; m_fv = 0; m_code = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, w_trk, w_pop, r_trk, r_pop, b_dec, aw_was_full;
        int head;
        logic [7:0] ne;
        if (!rst_n) begin
            model_reset();
            return;
        end
        aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
        ar_hs = arvalid && arready; r_hs = rvalid && rready;
        ne = '0;
        ne[0] = p_aw_stall && ({awid, awaddr, awlen, awsize, awburst} != p_aw);
        ne[1] = p_w_stall && ({wdata, wstrb, wlast} != p_w);
        ne[2] = p_ar_stall && ({arid, araddr, arlen, arsize, arburst} != p_ar);
        ne[3] = (p_aw_stall && !awvalid) || (p_w_stall && !wvalid) || (p_b_stall && !bvalid) ||
                (p_ar_stall && !arvalid) || (p_r_stall && !rvalid);
        // Write channel
        w_trk = 0; w_pop = 0;
        if (w_hs) begin
            if (m_aw_q.size() > 0 || aw_hs) begin
                w_trk = 1;
                head = (m_aw_q.size() > 0) ? m_aw_q[0] : int'(awlen);
                if (wlast != (m_wcnt == head)) ne[4] = 1;
                w_pop = wlast;
            end else begin
                ne[6] = 1;
            end
        end
        b_dec = b_hs && (m_bpend > 0);
        if (b_hs && m_bpend == 0) ne[6] = 1;
        aw_was_full = (m_aw_q.size() == MAXO);
        if (aw_hs) begin
            if (!aw_was_full || w_pop) m_aw_q.push_back(int'(awlen));
            if (aw_was_full && (!w_pop || (m_bpend == MAXO && !b_dec))) ne[7] = 1;
        end
        if (w_pop) void'(m_aw_q.pop_front());
        m_bpend = m_bpend - int'(b_dec) + int'(w_pop);
        if (m_bpend > MAXO) m_bpend = MAXO;
        if (w_pop) m_wcnt = 0;
        else if (w_trk && m_wcnt < 255) m_wcnt++;
        // Read channel
        r_trk = 0; r_pop = 0;
        if (r_hs) begin
            if (m_ar_q.size() > 0) begin
                r_trk = 1;
                if (rlast != (m_rcnt == m_ar_q[0])) ne[5] = 1;
                r_pop = rlast;
            end else begin
                ne[6] = 1;
            end
        end
        if (ar_hs) begin
            if (m_ar_q.size() < MAXO || r_pop) m_ar_q.push_back(int'(arlen));
            else ne[7] = 1;
        end
        if (r_pop) void'(m_ar_q.pop_front());
        if (r_pop) m_rcnt = 0;
        else if (r_trk && m_rcnt < 255) m_rcnt++;
        // Previous-cycle state
        p_aw_stall = awvalid && !awready; p_w_stall = wvalid && !wready;
        p_b_stall = bvalid && !bready; p_ar_stall = arvalid && !arready;
        p_r_stall = rvalid && !rready;
        p_aw = {awid, awaddr, awlen, awsize, awburst};
        p_ar = {arid, araddr, arlen, arsize, arburst};
        p_w = {wdata, wstrb, wlast};
        // Reporting
        if (clr) begin
            m_vec = '0; m_fv = 0; m_code = 0; m_cnt = 0;
        end
        m_vec = m_vec | ne;
        if (ne != 0) begin
            if (!m_fv) begin
                m_fv = 1;
                for (int i = 0; i < 8; i++) begin
                    if (ne[i]) begin
                        m_code = i;
                        break;
                    end
                end
            end
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic compare_all();
        check("err_vec", err_vec, m_vec);
        check("err_first_valid", err_first_valid, m_fv);
        check("err_first_code", err_first_code, m_code);
        check("err_cnt", err_cnt, m_cnt);
        check("wr_outstanding", wr_outstanding, m_aw_q.size() + m_bpend);
        check("rd_outstanding", rd_outstanding, m_ar_q.size());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 0; awready = 0;
        wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; wready = 0;
        bid = '0; bresp = '0; bvalid = 0; bready = 0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 0; arready = 0;
        rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0; rready = 0;
        clr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #1;
        check("rst_err_vec", err_vec, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_valid", err_first_valid, 0);
        check("rst_wr_out", wr_outstanding, 0);
        check("rst_rd_out", rd_outstanding, 0);
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    function automatic bit coin(input int unsigned n);
        return $urandom_range(n - 1) == 0;
    endfunction

    initial begin
        idle();
        #1;
        do_reset();

        // T1: clean write burst
        awvalid = 1; awready = 1; awlen = 8'd3; awaddr = 32'h40;
        cycle();
        check("t1_wr_after_aw", wr_outstanding, 1);
        awvalid = 0; awready = 0;
        for (int i = 0; i < 4; i++) begin
            wvalid = 1; wready = 1; wdata = 32'(i); wstrb = 4'hf; wlast = (i == 3);
            cycle();
        end
        check("t1_wr_before_b", wr_outstanding, 1);
        wvalid = 0; wready = 0; wlast = 0;
        bvalid = 1; bready = 1;
        cycle();
        bvalid = 0; bready = 0;
        check("t1_wr_after_b", wr_outstanding, 0);
        check("t1_err_vec", err_vec, 0);

        // T2: AR address changes while stalled
        do_reset();
        arvalid = 1; arready = 0; araddr = 32'h100;
        cycle();
        araddr = 32'h104;
        cycle();
        check("t2_err_vec", err_vec, 8'h04);
        check("t2_code", err_first_code, 2);
        check("t2_cnt", err_cnt, 1);
        arready = 1;
        cycle();
        arvalid = 0; arready = 0;
        cycle();
        check("t2_cnt_hold", err_cnt, 1);
        check("t2_rd_out", rd_outstanding, 1);

        // T3: early WLAST, B still legitimate
        do_reset();
        awvalid = 1; awready = 1; awlen = 8'd1;
        cycle();
        awvalid = 0; awready = 0;
        wvalid = 1; wready = 1; wlast = 1;
        cycle();
        check("t3_err_vec", err_vec, 8'h10);
        wvalid = 0; wready = 0; wlast = 0;
        bvalid = 1; bready = 1;
        cycle();
        bvalid = 0; bready = 0;
        check("t3_no_orphan", err_vec, 8'h10);
        check("t3_wr_out", wr_outstanding, 0);

        // T4: AR FIFO overflow, then push+pop while full
        do_reset();
        arlen = 8'd0; arready = 1; arvalid = 1;
        for (int i = 0; i < 8; i++) begin
            araddr = 32'(i * 16);
            cycle();
        end
        check("t4_full_noerr", err_vec, 0);
        araddr = 32'h900;
        cycle();
        check("t4_overflow", err_vec, 8'h80);
        check("t4_rd_full", rd_outstanding, 8);
        araddr = 32'hA00; rvalid = 1; rready = 1; rlast = 1;
        cycle();
        check("t4_pushpop_cnt", err_cnt, 1);
        arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
        cycle();
        check("t4_rd_still8", rd_outstanding, 8);

        // T5: B and R orphans in the same cycle
        do_reset();
        bvalid = 1; bready = 1; rvalid = 1; rready = 1; rlast = 1;
        cycle();
        check("t5_err_vec", err_vec, 8'h40);
        check("t5_cnt", err_cnt, 1);
        check("t5_code", err_first_code, 6);
        bvalid = 0; bready = 0; rvalid = 0; rready = 0; rlast = 0;
        cycle();

        // T6: VALID drop, clr with AR_STABLE, then reset mid-burst
        do_reset();
        wvalid = 1; wready = 0; wdata = 32'h55;
        cycle();
        wvalid = 0;
        cycle();
        check("t6_drop", err_vec, 8'h08);
        check("t6_drop_code", err_first_code, 3);
        arvalid = 1; arready = 0; araddr = 32'h10;
        cycle();
        araddr = 32'h14; clr = 1;
        cycle();
        clr = 0;
        check("t6_clr_vec", err_vec, 8'h04);
        check("t6_clr_cnt", err_cnt, 1);
        check("t6_clr_code", err_first_code, 2);
        arready = 1;
        cycle();
        arvalid = 0; arready = 0;
        awvalid = 1; awready = 1; awlen = 8'd3;
        cycle();
        awvalid = 0; awready = 0;
        wvalid = 1; wready = 1; wlast = 0;
        cycle();
        cycle();
        do_reset();
        cycle();
        check("t6_post_rst_vec", err_vec, 0);
        check("t6_post_rst_wr", wr_outstanding, 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit slow;
            int exp_head;
            slow = ((c / 256) % 2) == 1;
            if (!(awvalid && !awready) || coin(16)) begin
                awvalid = coin(3);
                awid = ID_W'($urandom); awaddr = $urandom; awlen = LEN_W'($urandom_range(3));
                awsize = 3'($urandom); awburst = 2'($urandom);
            end
            awready = !coin(4);
            if (!(wvalid && !wready) || coin(16)) begin
                if (m_aw_q.size() > 0 || awvalid) wvalid = slow ? coin(8) : !coin(4);
                else wvalid = coin(16);
                wdata = $urandom; wstrb = 4'($urandom);
                exp_head = (m_aw_q.size() > 0) ? m_aw_q[0] : 0;
                wlast = coin(8) ? 1'($urandom_range(1)) : (m_wcnt == exp_head);
            end
            wready = !coin(4);
            if (!(bvalid && !bready) || coin(16)) begin
                bvalid = (m_bpend > 0) ? coin(2) : coin(32);
                bid = ID_W'($urandom); bresp = 2'($urandom);
            end
            bready = !coin(4);
            if (!(arvalid && !arready) || coin(16)) begin
                arvalid = coin(3);
                arid = ID_W'($urandom); araddr = $urandom; arlen = LEN_W'($urandom_range(3));
                arsize = 3'($urandom); arburst = 2'($urandom);
            end
            arready = !coin(4);
            if (!(rvalid && !rready) || coin(16)) begin
                if (m_ar_q.size() > 0) rvalid = slow ? coin(8) : !coin(4);
                else rvalid = coin(16);
                rid = ID_W'($urandom); rdata = $urandom; rresp = 2'($urandom);
                exp_head = (m_ar_q.size() > 0) ? m_ar_q[0] : 0;
                rlast = coin(8) ? 1'($urandom_range(1)) : (m_rcnt == exp_head);
            end
            rready = !coin(4);
            clr = coin(32);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
